// File: rtl/pcie_rq_arbiter.sv
// Purpose: packet-level round-robin arbiter sharing the PCIe RQ AXI-stream between port 0 (ATS invalidation completions) and port 1 (user requests).
// Latency: one cycle; a beat accepted on cycle N is presented on m_axis on cycle N+1 (registered output).
// Backpressure: s_n tready is combinational from m_axis_tready; a stalled full output register holds both inputs off in the same cycle.
//
// Ports:
//   clk, rst             sole clock; asynchronous active-low reset
//   s0_axis_*            port 0 input stream (tdata/tkeep/tvalid/tlast/tuser, tready out)
//   s1_axis_*            port 1 input stream
//   m_axis_*             registered RQ output toward the PCIe core (tready in)
//   busy                 high while a multi-beat packet holds the lock
//   cur_port             port owning the current or most recent packet
//   pkt_cnt0, pkt_cnt1   wrapping count of completed packets per port
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 137,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic                          s0_axis_tvalid,
    input  logic                          s0_axis_tlast,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    output logic                          s0_axis_tready,

    input  logic [AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic                          s1_axis_tvalid,
    input  logic                          s1_axis_tlast,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    output logic                          s1_axis_tready,

    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    input  logic                          m_axis_tready,

    output logic                          busy,
    output logic                          cur_port,
    output logic [CNT_WIDTH-1:0]          pkt_cnt0,
    output logic [CNT_WIDTH-1:0]          pkt_cnt1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       prefer;
    logic       sel;        // port currently steered to the output register
    logic       gnt;        // some port owns the output this cycle
    logic       can_load;
    logic       accept;
    logic       acc_last;

    // IDLE grants in the same cycle so back-to-back packets see no bubble;
    // a locked state pins the grant to its owner until tlast.
    always_comb begin
        sel = 1'b0;
        gnt = 1'b0;
        case (state)
            ST_LOCK0: begin
                sel = 1'b0;
                gnt = 1'b1;
            end
            ST_LOCK1: begin
                sel = 1'b1;
                gnt = 1'b1;
            end
            default: begin
                gnt = s0_axis_tvalid | s1_axis_tvalid;
                if (s0_axis_tvalid && s1_axis_tvalid)
                    sel = prefer;
                else
                    sel = s1_axis_tvalid;
            end
        endcase
    end

    assign can_load = !m_axis_tvalid | m_axis_tready;

    // Gated by reset so neither source sees ready while the block is held in reset.
    assign s0_axis_tready = rst & gnt & !sel & can_load;
    assign s1_axis_tready = rst & gnt &  sel & can_load;

    assign accept   = sel ? (s1_axis_tvalid & s1_axis_tready) : (s0_axis_tvalid & s0_axis_tready);
    assign acc_last = sel ? s1_axis_tlast : s0_axis_tlast;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (acc_last)
                state_nxt = ST_IDLE;
            else
                state_nxt = sel ? ST_LOCK1 : ST_LOCK0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            prefer   <= 1'b0;
            cur_port <= 1'b0;
            busy     <= 1'b0;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            // Round-robin pointer only moves on the first beat of a packet.
            if (accept && state == ST_IDLE) begin
                prefer   <= !sel;
                cur_port <= sel;
            end
            if (accept && acc_last) begin
                if (sel)
                    pkt_cnt1 <= pkt_cnt1 + 1'b1;
                else
                    pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
        end
    end

    // Output register: load on accept, drain when the core takes the beat, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tdata  <= sel ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tkeep  <= sel ? s1_axis_tkeep : s0_axis_tkeep;
            m_axis_tlast  <= acc_last;
            m_axis_tuser  <= sel ? s1_axis_tuser : s0_axis_tuser;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Purpose: self-checking bench for pcie_rq_arbiter using a directed vector table plus hand sequences.
// Latency: checks inputs-ready combinationally before each edge and registered outputs #1 after it.
// Backpressure: vectors drive m_axis_tready low mid-packet to exercise stall behaviour.
module tb_pcie_rq_arbiter;

    localparam int DW = 512;
    localparam int UW = 137;
    localparam int CW = 16;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s0_tdata,  s1_tdata,  m_tdata;
    logic [DW/8-1:0] s0_tkeep,  s1_tkeep,  m_tkeep;
    logic            s0_tvalid, s1_tvalid, m_tvalid;
    logic            s0_tlast,  s1_tlast,  m_tlast;
    logic [UW-1:0]   s0_tuser,  s1_tuser,  m_tuser;
    logic            s0_tready, s1_tready, m_tready;
    logic            busy, cur_port;
    logic [CW-1:0]   pkt_cnt0, pkt_cnt1;

    int checks = 0;
    int errors = 0;

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tvalid(s0_tvalid),
        .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tvalid(s1_tvalid),
        .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser), .s1_axis_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .busy(busy), .cur_port(cur_port), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_data(input logic [7:0] b);
        return {64{b}};
    endfunction
    function automatic logic [DW/8-1:0] mk_keep(input logic [7:0] b);
        return {8{b}};
    endfunction
    function automatic logic [UW-1:0] mk_user(input logic [7:0] b);
        return {b, {16{b}}, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic l0, input logic [7:0] d0,
                         input logic v1, input logic l1, input logic [7:0] d1,
                         input logic mr);
        s0_tvalid = v0; s0_tlast = l0; s0_tdata = mk_data(d0); s0_tkeep = mk_keep(d0); s0_tuser = mk_user(d0);
        s1_tvalid = v1; s1_tlast = l1; s1_tdata = mk_data(d1); s1_tkeep = mk_keep(d1); s1_tuser = mk_user(d1);
        m_tready  = mr;
    endtask

    typedef struct {
        logic       s0v; logic s0l; logic [7:0] s0d;
        logic       s1v; logic s1l; logic [7:0] s1d;
        logic       mr;
        logic       e_s0r; logic e_s1r;
        logic       e_mv; logic [7:0] e_md; logic e_ml;
        logic       e_busy; logic e_cp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic s0v, input logic s0l, input logic [7:0] s0d,
                                 input logic s1v, input logic s1l, input logic [7:0] s1d,
                                 input logic mr, input logic e_s0r, input logic e_s1r,
                                 input logic e_mv, input logic [7:0] e_md, input logic e_ml,
                                 input logic e_busy, input logic e_cp);
        vec_t v;
        v.s0v = s0v; v.s0l = s0l; v.s0d = s0d; v.s1v = s1v; v.s1l = s1l; v.s1d = s1d; v.mr = mr;
        v.e_s0r = e_s0r; v.e_s1r = e_s1r; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml;
        v.e_busy = e_busy; v.e_cp = e_cp;
        return v;
    endfunction

    int bubbles;

    initial begin
        //               s0v s0l s0d    s1v s1l s1d    mr  s0r s1r mv  md     ml  busy cp
        // single-beat on port 0
        vecs[0]  = mkv(1, 1, 8'h30,  0, 0, 8'h00,  1,  1,  0,  1,  8'h30, 1,  0,   0);
        // both ports single-beat: alternate starting at port 1 (prefer=1)
        vecs[1]  = mkv(1, 1, 8'hA0,  1, 1, 8'hB1,  1,  0,  1,  1,  8'hB1, 1,  0,   1);
        vecs[2]  = mkv(1, 1, 8'hA0,  1, 1, 8'hB1,  1,  1,  0,  1,  8'hA0, 1,  0,   0);
        vecs[3]  = mkv(1, 1, 8'hA2,  1, 1, 8'hB3,  1,  0,  1,  1,  8'hB3, 1,  0,   1);
        vecs[4]  = mkv(1, 1, 8'hA2,  1, 1, 8'hB3,  1,  1,  0,  1,  8'hA2, 1,  0,   0);
        // port 1 four-beat packet, port 0 waits from beat 2
        vecs[5]  = mkv(0, 0, 8'h00,  1, 0, 8'h11,  1,  0,  1,  1,  8'h11, 0,  1,   1);
        vecs[6]  = mkv(1, 1, 8'h40,  1, 0, 8'h12,  1,  0,  1,  1,  8'h12, 0,  1,   1);
        vecs[7]  = mkv(1, 1, 8'h40,  1, 0, 8'h13,  1,  0,  1,  1,  8'h13, 0,  1,   1);
        vecs[8]  = mkv(1, 1, 8'h40,  1, 1, 8'h14,  1,  0,  1,  1,  8'h14, 1,  0,   1);
        vecs[9]  = mkv(1, 1, 8'h40,  0, 0, 8'h00,  1,  1,  0,  1,  8'h40, 1,  0,   0);
        // port 0 three-beat packet with 3-cycle stall after beat 1
        vecs[10] = mkv(1, 0, 8'h50,  0, 0, 8'h00,  1,  1,  0,  1,  8'h50, 0,  1,   0);
        vecs[11] = mkv(1, 0, 8'h51,  1, 1, 8'h99,  0,  0,  0,  1,  8'h50, 0,  1,   0);
        vecs[12] = mkv(1, 0, 8'h51,  1, 1, 8'h99,  0,  0,  0,  1,  8'h50, 0,  1,   0);
        vecs[13] = mkv(1, 0, 8'h51,  1, 1, 8'h99,  0,  0,  0,  1,  8'h50, 0,  1,   0);
        vecs[14] = mkv(1, 0, 8'h51,  0, 0, 8'h00,  1,  1,  0,  1,  8'h51, 0,  1,   0);
        vecs[15] = mkv(1, 1, 8'h52,  0, 0, 8'h00,  1,  1,  0,  1,  8'h52, 1,  0,   0);
        vecs[16] = mkv(0, 0, 8'h00,  0, 0, 8'h00,  1,  0,  0,  0,  8'h00, 0,  0,   0);

        // reset with port 0 requesting: ready must stay low
        rst = 1'b0;
        drive(1, 1, 8'h30, 1, 1, 8'h31, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        chk("rst_m_tdata", m_tdata, 512'(0));
        chk("rst_s0_tready", 512'(s0_tready), 512'(0));
        chk("rst_s1_tready", 512'(s1_tready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_cnts", 512'({pkt_cnt1, pkt_cnt0}), 512'(0));
        drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].s0v, vecs[i].s0l, vecs[i].s0d, vecs[i].s1v, vecs[i].s1l, vecs[i].s1d, vecs[i].mr);
            @(negedge clk);
            chk($sformatf("v%0d_s0_tready", i), 512'(s0_tready), 512'(vecs[i].e_s0r));
            chk($sformatf("v%0d_s1_tready", i), 512'(s1_tready), 512'(vecs[i].e_s1r));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_tvalid", i), 512'(m_tvalid), 512'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_m_tdata", i), m_tdata, mk_data(vecs[i].e_md));
                chk($sformatf("v%0d_m_tkeep", i), 512'(m_tkeep), 512'(mk_keep(vecs[i].e_md)));
                chk($sformatf("v%0d_m_tuser", i), 512'(m_tuser), 512'(mk_user(vecs[i].e_md)));
                chk($sformatf("v%0d_m_tlast", i), 512'(m_tlast), 512'(vecs[i].e_ml));
            end
            chk($sformatf("v%0d_busy", i), 512'(busy), 512'(vecs[i].e_busy));
            chk($sformatf("v%0d_cur_port", i), 512'(cur_port), 512'(vecs[i].e_cp));
        end
        chk("tbl_pkt_cnt0", 512'(pkt_cnt0), 512'(5));
        chk("tbl_pkt_cnt1", 512'(pkt_cnt1), 512'(3));

        // reset during beat 2 of a port 1 three-beat packet
        drive(0, 0, 8'h00, 1, 0, 8'h70, 1);
        @(posedge clk);
        #1;
        chk("mid_beat1", m_tdata, mk_data(8'h70));
        drive(1, 1, 8'h60, 1, 0, 8'h71, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", 512'(m_tvalid), 512'(0));
        chk("mid_rst_cnts", 512'({pkt_cnt1, pkt_cnt0}), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_s1_tready", 512'(s1_tready), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 8'h60, 1, 1, 8'h62, 1);
        #1;
        chk("post_rst_s0_tready", 512'(s0_tready), 512'(1));
        chk("post_rst_s1_tready", 512'(s1_tready), 512'(0));
        @(posedge clk);
        #1;
        chk("post_rst_m_tdata", m_tdata, mk_data(8'h60));
        chk("post_rst_cur_port", 512'(cur_port), 512'(0));
        chk("post_rst_pkt_cnt0", 512'(pkt_cnt0), 512'(1));

        // 65536 single-beat packets on port 1: counter wraps, port 0 count untouched
        drive(0, 0, 8'h00, 1, 1, 8'h63, 1);
        bubbles = 0;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
            #1;
            if (!m_tvalid) bubbles++;
            if (i == 65534) chk("wrap_all_ones", 512'(pkt_cnt1), 512'(16'hFFFF));
        end
        chk("wrap_bubbles", 512'(bubbles), 512'(0));
        chk("wrap_pkt_cnt1", 512'(pkt_cnt1), 512'(0));
        chk("wrap_pkt_cnt0", 512'(pkt_cnt0), 512'(1));
        drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
